// File: rtl/rom_arb_pkg.sv
// Shared widths and FSM encoding for the two-client ROM burst arbiter.
package rom_arb_pkg;
    localparam int AW = 3;
    localparam int DW = 9;
    localparam int LW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
// Zero latency; no backpressure (pure function of the current requests).
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_win_vld,
    output logic o_win_id
);
    assign o_win_vld = i_req0 | i_req1;
    assign o_win_id  = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one combinational ROM between two requesters.
// Grant one cycle after sampling, first word the cycle after; requests are ignored while a burst runs.
module rom_burst_arbiter #(
    parameter int AW = rom_arb_pkg::AW,
    parameter int DW = rom_arb_pkg::DW,
    parameter int LW = rom_arb_pkg::LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [LW-1:0] len0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [LW-1:0] len1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data
);
    import rom_arb_pkg::*;

    state_t        r_state,    w_state_nxt;
    logic [LW-1:0] r_cnt,      w_cnt_nxt;
    logic          r_owner,    w_owner_nxt;
    logic          r_last,     w_last_nxt;
    logic          r_gnt0,     w_gnt0_nxt;
    logic          r_gnt1,     w_gnt1_nxt;
    logic          r_rvalid0,  w_rvalid0_nxt;
    logic          r_rvalid1,  w_rvalid1_nxt;
    logic [DW-1:0] r_rdata,    w_rdata_nxt;
    logic          r_busy,     w_busy_nxt;
    logic [AW-1:0] r_rom_addr, w_rom_addr_nxt;
    logic          w_win_vld;
    logic          w_win_id;

    rr_pick2 u_pick (
        .i_req0    (req0),
        .i_req1    (req1),
        .i_last    (r_last),
        .o_win_vld (w_win_vld),
        .o_win_id  (w_win_id)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_gnt0_nxt     = 1'b0;
        w_gnt1_nxt     = 1'b0;
        w_rvalid0_nxt  = 1'b0;
        w_rvalid1_nxt  = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_busy_nxt     = r_busy;
        w_rom_addr_nxt = r_rom_addr;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_gnt0_nxt     = ~w_win_id;
                    w_gnt1_nxt     = w_win_id;
                    w_rom_addr_nxt = w_win_id ? addr1 : addr0;
                    w_cnt_nxt      = w_win_id ? len1 : len0;
                    w_owner_nxt    = w_win_id;
                    w_last_nxt     = w_win_id;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = BURST;
                end
            end
            BURST: begin
                // ROM read is combinational, so the word for rom_addr is captured on this edge
                w_rdata_nxt    = rom_data;
                w_rvalid0_nxt  = ~r_owner;
                w_rvalid1_nxt  = r_owner;
                w_rom_addr_nxt = r_rom_addr + AW'(1);
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - LW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_gnt0     <= w_gnt0_nxt;
            r_gnt1     <= w_gnt1_nxt;
            r_rvalid0  <= w_rvalid0_nxt;
            r_rvalid1  <= w_rvalid1_nxt;
            r_rdata    <= w_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_rom_addr <= w_rom_addr_nxt;
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign rom_addr = r_rom_addr;
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter: a transaction-level model predicts grants and beats per sampling edge.
module tb_rom_burst_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [2:0] len0 = '0, len1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [8:0] rdata;
    logic [2:0] rom_addr;
    logic [8:0] rom_data;

    logic [8:0] rom_img [8] = '{9'h04C, 9'h096, 9'h01D, 9'h1D5, 9'h1AC, 9'h080, 9'h195, 9'h1EC};
    assign rom_data = rom_img[rom_addr];

    rom_burst_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .len0(len0),
        .req1(req1), .addr1(addr1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         id;
        logic [8:0] d;
    } item_t;

    item_t gq[$];
    item_t dq[$];
    int    cyc = 0;
    int    free_at = 0;
    bit    last_w = 1'b1;
    bit    rst_edge = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    tmo_seen = 0;
    int    tmo_acc = 0;
    bit    done_req = 1'b0;
    bit    done_ack = 1'b0;
    bit    hold0 = 1'b0, hold1 = 1'b0, rnd_en = 1'b0;

    // Reference model: at every edge where the arbiter is free, the spec's round-robin rule picks a winner
    always @(posedge clk) begin
        item_t it;
        int    a, l;
        bit    w;
        cyc = cyc + 1;
        if (rst) begin
            gq.delete();
            dq.delete();
            free_at  = 0;
            last_w   = 1'b1;
            rst_edge = 1'b1;
        end else begin
            rst_edge = 1'b0;
            if (cyc >= free_at && (req0 || req1)) begin
                w = (req0 && req1) ? !last_w : req1;
                a = w ? int'(addr1) : int'(addr0);
                l = w ? int'(len1) : int'(len0);
                it.cyc = cyc; it.id = w; it.d = '0;
                gq.push_back(it);
                for (int k = 0; k <= l; k++) begin
                    it.cyc = cyc + 1 + k;
                    it.d   = rom_img[(a + k) % 8];
                    dq.push_back(it);
                end
                free_at = cyc + l + 2;
                last_w  = w;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant or a data beat
    always @(negedge clk) begin
        item_t e;
        if (cyc > 0) begin
            if (rst_edge) begin
                total++;
                if ({gnt0, gnt1, rvalid0, rvalid1, busy} != 5'b0 || rdata != 9'h0 || rom_addr != 3'h0) begin
                    bad++;
                    $display("FAIL reset_state cyc=%0d got gnt=%b%b rv=%b%b busy=%b rdata=%h rom_addr=%0d want all zero",
                             cyc, gnt1, gnt0, rvalid1, rvalid0, busy, rdata, rom_addr);
                end
            end else begin
                if (gnt0 || gnt1) begin
                    total++;
                    if (gq.size() == 0) begin
                        bad++;
                        $display("FAIL grant_unexpected cyc=%0d got gnt=%b%b want none", cyc, gnt1, gnt0);
                    end else begin
                        e = gq.pop_front();
                        if ((gnt0 && gnt1) || e.cyc != cyc || e.id != gnt1) begin
                            bad++;
                            $display("FAIL grant cyc=%0d got gnt=%b%b want id=%0d at cyc=%0d",
                                     cyc, gnt1, gnt0, e.id, e.cyc);
                        end
                    end
                end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                    total++; bad++;
                    e = gq.pop_front();
                    $display("FAIL grant_missing cyc=%0d got none want id=%0d", cyc, e.id);
                end
                if (rvalid0 || rvalid1) begin
                    total++;
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL beat_unexpected cyc=%0d got rv=%b%b rdata=%h want none",
                                 cyc, rvalid1, rvalid0, rdata);
                    end else begin
                        e = dq.pop_front();
                        if ((rvalid0 && rvalid1) || e.cyc != cyc || e.id != rvalid1 || e.d != rdata) begin
                            bad++;
                            $display("FAIL beat cyc=%0d got rv=%b%b rdata=%h want id=%0d rdata=%h at cyc=%0d",
                                     cyc, rvalid1, rvalid0, rdata, e.id, e.d, e.cyc);
                        end
                    end
                end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                    total++; bad++;
                    e = dq.pop_front();
                    $display("FAIL beat_missing cyc=%0d got none want id=%0d rdata=%h", cyc, e.id, e.d);
                end
                total++;
                if (busy != (cyc + 1 < free_at)) begin
                    bad++;
                    $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, (cyc + 1 < free_at));
                end
            end
        end
        if (tmo_seen != tmo_acc) begin
            total++; bad++;
            tmo_acc++;
        end
        if (done_req && !done_ack) begin
            total++;
            if (gq.size() != 0 || dq.size() != 0) begin
                bad++;
                $display("FAIL drain got grants_left=%0d beats_left=%0d want 0 0", gq.size(), dq.size());
            end
            done_ack = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk);
        if (rnd_en) rst = ($urandom_range(299) == 0);
        if (gnt0) begin
            if (hold0 && rnd_en) hold0 = ($urandom_range(1) == 0);
            if (!hold0) req0 = 1'b0;
        end
        if (gnt1) begin
            if (hold1 && rnd_en) hold1 = ($urandom_range(1) == 0);
            if (!hold1) req1 = 1'b0;
        end
        if (rnd_en) begin
            if (!req0) begin
                addr0 = 3'($urandom); len0 = 3'($urandom);
                if ($urandom_range(2) == 0) begin req0 = 1'b1; hold0 = ($urandom_range(3) == 0); end
            end
            if (!req1) begin
                addr1 = 3'($urandom); len1 = 3'($urandom);
                if ($urandom_range(2) == 0) begin req1 = 1'b1; hold1 = ($urandom_range(3) == 0); end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (!busy && !req0 && !req1) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL timeout_idle %s got busy=%b want idle within 400 cycles", tag, busy);
            tmo_seen++;
        end
    endtask

    task automatic wait_gnt(input bit id, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (id ? gnt1 : gnt0) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL timeout_gnt %s got no gnt%0d want one within 100 cycles", tag, id);
            tmo_seen++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // single-word burst at address 2
        req0 = 1'b1; addr0 = 3'd2; len0 = 3'd0;
        wait_idle("single");

        // four-word burst wrapping 7 -> 0
        req1 = 1'b1; addr1 = 3'd6; len1 = 3'd3;
        wait_idle("wrap");

        // continuous contention from reset alternates 0,1,0,1,...
        do_reset();
        hold0 = 1'b1; hold1 = 1'b1;
        req0 = 1'b1; addr0 = 3'd1; len0 = 3'd0;
        req1 = 1'b1; addr1 = 3'd5; len1 = 3'd0;
        repeat (16) step();
        hold0 = 1'b0; hold1 = 1'b0;
        wait_idle("contend");

        // req1 arriving mid-burst waits for the full 8-word burst
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        repeat (3) step();
        req1 = 1'b1; addr1 = 3'd5; len1 = 3'd1;
        wait_idle("midburst");

        // reset on the third beat drops the burst
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        wait_gnt(1'b0, "pre_reset");
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; addr0 = 3'd3; len0 = 3'd1;
        wait_idle("post_reset");

        // addr/len changes after grant do not disturb the burst
        req0 = 1'b1; addr0 = 3'd4; len0 = 3'd2;
        wait_gnt(1'b0, "capture");
        addr0 = 3'd1; len0 = 3'd0;
        wait_idle("capture");

        rnd_en = 1'b1;
        repeat (3000) step();
        rnd_en = 1'b0; rst = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
        wait_idle("random");
        step();
        step();

        done_req = 1'b1;
        for (int i = 0; i < 5 && !done_ack; i++) @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares the single 8x9 ROM between two requesters.
- Each requester asks for a burst of 1..8 consecutive words starting at a given address. The arbiter drives the ROM address and returns registered data to the winner, one word per cycle.
- Sits between the ROM (combinational read) and two client FSMs.

Parameters:
AW, 3, ROM address width; depth 2**AW words
DW, 9, ROM data width
LW, 3, burst-length field width; burst = len+1 words

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 request; held until gnt0
addr0  in  AW  requester 0 start address; stable while req0 high
len0  in  LW  requester 0 burst length minus one
req1  in  1  requester 1 request
addr1  in  AW  requester 1 start address
len1  in  LW  requester 1 burst length minus one
gnt0  out  1  one-cycle grant pulse to requester 0
gnt1  out  1  one-cycle grant pulse to requester 1
rvalid0  out  1  rdata valid for requester 0
rvalid1  out  1  rdata valid for requester 1
rdata  out  DW  registered ROM word, shared by both requesters
busy  out  1  high while a burst is in progress
rom_addr  out  AW  address to ROM, registered
rom_data  in  DW  ROM read data, combinational from rom_addr

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: gnt0/1=0, rvalid0/1=0, rdata=0, busy=0, rom_addr=0, state=IDLE, cnt=0, owner=0, last=1.
- States: IDLE and BURST.
- IDLE behaviour:
  - Samples req0/req1 at each edge.
  - With one request pending, that requester wins.
  - With both pending, the one not equal to `last` wins.
  - On a win at edge E0, the following are registered:
    - gnt_winner=1
    - rom_addr=addr_winner
    - cnt=len_winner
    - owner=winner
    - last=winner
    - busy=1
    - state=BURST
- BURST behaviour, each edge:
  - gnt=0.
  - rdata<=rom_data.
  - rvalid_owner<=1, other rvalid=0.
  - rom_addr<=rom_addr+1, modulo 2**AW, so 7 wraps to 0.
  - If cnt==0: state<=IDLE and busy<=0. Otherwise cnt<=cnt-1.
- Outside BURST, every edge sets rvalid0/1=0. rdata holds its last value.
- Latency:
  - gnt pulses in the cycle after the sampling edge.
  - First rvalid follows in the next cycle.
  - rvalid then stays high for exactly len+1 consecutive cycles.
- Re-arbitration:
  - The IDLE cycle after the last beat re-samples requests, so there is one bubble cycle between bursts.
  - A requester that keeps req high after its burst competes again.
  - Round-robin via `last` guarantees alternation under continuous contention.
- Requests arriving during BURST are ignored until IDLE. req has no effect except in IDLE.
- addr/len are captured only at grant; later changes have no effect on the burst in progress.
- Reset mid-burst: at the reset edge all outputs return to reset values. No further rvalid is produced and the burst is dropped.
- Arithmetic: rom_addr increment is AW bits with natural wrap. cnt is LW bits. No carry outputs.

Decomposition:
- Shared package rom_arb_pkg holds:
  - localparams AW=3, DW=9, LW=3
  - state encoding IDLE=1'b0, BURST=1'b1
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker (req0, req1, last -> win_valid, win_id).
- The ROM is instantiated by the parent, not inside this block.
- The bench instantiates the existing ROM with its standard image:
  - 0:0x04C
  - 1:0x096
  - 2:0x01D
  - 3:0x1D5
  - 4:0x1AC
  - 5:0x080
  - 6:0x195
  - 7:0x1EC

Test Plan:
- Reset, then req0=1, addr0=2, len0=0:
  - gnt0 pulses 1 cycle after the sampling edge.
  - Next cycle rvalid0=1, rdata=0x01D, for 1 cycle only.
  - busy then falls.
- req1=1, addr1=6, len1=3:
  - rvalid1 for 4 consecutive cycles with rdata 0x195, 0x1EC, 0x04C, 0x096, exercising the 7->0 wrap.
  - rvalid0 stays 0 throughout.
- From reset, req0 and req1 raised together and held, len=0 each:
  - Grants alternate gnt0, gnt1, gnt0, gnt1.
  - One IDLE cycle between each burst.
- req1 raised mid-burst of requester 0 (addr0=0, len0=7):
  - Requester 0 receives all 8 words 0x04C..0x1EC in order.
  - gnt1 only after busy falls.
- rst asserted on the 3rd beat of a len=7 burst:
  - Next cycle all of rvalid0/1, gnt0/1, busy, rdata, rom_addr are 0.
  - After release with req0 high, a fresh grant to requester 0.
- addr0 changed from 4 to 1 during a burst started at addr0=4, len0=2:
  - Data stays 0x1AC, 0x080, 0x195, unaffected by the change.
